mem_program_loader: RTL and testbench
=====================================

# mem_program_loader

Serial program loader that fills the writable program memory before the core runs. Accepts a length-prefixed, checksummed byte stream over a valid/ready handshake. Assembles little-endian 32-bit instruction words and issues one word write per four bytes to the program memory write port. Holds the CPU in reset while a load is in progress or after a failed load.

## Interface
Parameters:
- DEPTH, 513: program memory depth in 32-bit words; maximum accepted word count.
- ADDR_BASE, 32'h0000_0000: byte address of word 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle write strobe to program memory.
- wr_addr  output  32  byte address of the write: ADDR_BASE + 4*index.
- wr_data  output  32  instruction word.
- cpu_hold  output  1  holds the core in reset.
- done  output  1  load completed with a good checksum.
- error  output  1  load failed (bad length or checksum).
- words_written  output  16  number of words written in the current or last load.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (least-significant byte of each word first), then one checksum byte.
- Checksum = 8-bit sum (mod 256) of all 4*N data bytes. The length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR + start -> LEN_LO. This clears done, error, words_written, the byte counter and the checksum accumulator.
- start in LEN_LO/LEN_HI/DATA/CSUM is ignored.
- LEN_LO + byte accepted -> LEN_HI.
- LEN_HI + byte accepted:
  - N > DEPTH -> ERROR.
  - N = 0 -> CSUM.
  - otherwise -> DATA.
- DATA: shift each byte into the word assembly register at lane (byte_cnt mod 4) and add it to the checksum.
  - On the 4th byte of a word: register wr_data and wr_addr, pulse wr_en, increment words_written.
  - After the word with index N-1 -> CSUM.
- CSUM + byte accepted:
  - byte equals accumulator -> DONE.
  - otherwise -> ERROR.
- Words already written stay in memory when a load ends in ERROR; cpu_hold guards them.
- in_ready = 1 in LEN_LO, LEN_HI, DATA, CSUM; 0 otherwise. A byte is accepted only when in_valid && in_ready.
- cpu_hold = 1 in LEN_LO..CSUM and in ERROR; 0 in IDLE and DONE.
- done = 1 only in DONE; error = 1 only in ERROR.
- Width rules:
  - Byte counter is 18 bits, so 4*DEPTH fits.
  - wr_addr = ADDR_BASE + {word_index, 2'b00}, 32-bit with wrap-around.
  - Checksum wraps mod 256.

## Timing
- Reset values: state IDLE; in_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 0, done 0, error 0, words_written 0.
- Reset mid-load aborts immediately to IDLE. Partial words are discarded and no wr_en is issued.
- start sampled at edge t puts the block in LEN_LO at t+1, with in_ready=1 and cpu_hold=1 from t+1.
- Throughput: one byte per cycle. in_valid may stay high continuously; gaps (in_valid=0) stall without effect.
- Write latency: 4th byte accepted at edge t -> wr_en=1 with stable wr_addr/wr_data during cycle t+1 (exactly one cycle). wr_addr and wr_data hold their last values afterwards.
- Back-to-back words produce wr_en pulses spaced 4 cycles apart at full rate.
- Checksum byte accepted at edge t -> done or error asserted from t+1, and cpu_hold drops at t+1 on success.
- Final-word write and state transition: the final wr_en pulse (cycle t+1 after the last data byte) coincides with the first CSUM cycle. in_ready is already 1 then.

## Test plan
- Single word: start; bytes 01 00 93 00 10 00 A3.
  - Expect one wr_en with wr_addr=0x0, wr_data=0x00100093.
  - Expect done=1, error=0, cpu_hold=0, words_written=1.
- Four words at full rate (in_valid held high): program ADDI/ADDI/ADDI/JAL, correct checksum.
  - Expect 4 wr_en pulses 4 cycles apart at addresses 0x0, 0x4, 0x8, 0xC.
  - Expect words_written=4 and done=1.
- Bad checksum: single word as above with checksum 0xA4.
  - Expect the word still written, error=1, done=0, cpu_hold=1.
- Oversize length: LEN=0x0202 (514 > 513).
  - Expect ERROR after LEN_HI, in_ready=0, no wr_en, cpu_hold=1.
- Zero length: bytes 00 00 00.
  - Expect no wr_en and done=1.
  - Then start with in_valid gaps, and an ignored start during DATA.
  - Expect correct completion of that second load.
- Reset mid-load: assert rst after 2 of 4 data bytes.
  - Expect all outputs at reset values immediately, no wr_en.
  - A fresh load afterwards completes normally.

Source files
------------

// File: rtl/mem_program_loader.sv
// Serial program loader: length-prefixed, checksummed byte stream in,
// little-endian 32-bit word writes out; holds the core while loading or after a failed load.
module mem_program_loader #(
    parameter int unsigned DEPTH     = 513,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state, state_nx;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [17:0] byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  csum;

    logic        accept;
    logic        start_load;
    logic [15:0] len_in;
    logic        word_end;
    logic        last_byte;

    assign accept     = in_valid && in_ready;
    assign start_load = start && (state == IDLE || state == DONE || state == ERROR);
    assign len_in     = {in_data, len_lo};
    assign word_end   = (byte_cnt[1:0] == 2'b11);
    assign last_byte  = word_end && ((byte_cnt + 18'd1) == {len, 2'b00});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nx = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (accept) begin
                    if ({1'b0, len_in} > DEPTH_W) state_nx = ERROR;
                    else if (len_in == 16'd0)     state_nx = CSUM;
                    else                          state_nx = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (accept && last_byte) state_nx = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nx = (in_data == csum) ? DONE : ERROR;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = LEN_LO;
            end
            ERROR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) state_nx = LEN_LO;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo        <= '0;
            len           <= '0;
            byte_cnt      <= '0;
            word_buf      <= '0;
            csum          <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            words_written <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_load) begin
                byte_cnt      <= '0;
                csum          <= '0;
                words_written <= '0;
            end
            if (accept && state == LEN_LO) len_lo <= in_data;
            if (accept && state == LEN_HI) len    <= len_in;
            if (accept && state == DATA) begin
                byte_cnt <= byte_cnt + 18'd1;
                csum     <= csum + in_data;
                case (byte_cnt[1:0])
                    2'd0:    word_buf[7:0]   <= in_data;
                    2'd1:    word_buf[15:8]  <= in_data;
                    2'd2:    word_buf[23:16] <= in_data;
                    default: ;
                endcase
                // Top lane goes straight into wr_data; lanes 0..2 come from the buffer.
                if (word_end) begin
                    wr_data       <= {in_data, word_buf};
                    wr_addr       <= ADDR_BASE + {14'd0, words_written, 2'b00};
                    wr_en         <= 1'b1;
                    words_written <= words_written + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_program_loader.sv
// Directed bench for mem_program_loader: hand-computed streams, write capture and status checks.
module tb_mem_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int          cyc    = 0;
    int          n_wr   = 0;
    int          base;
    logic [31:0] wa [64];
    logic [31:0] wd [64];
    int          wc [64];

    mem_program_loader #(
        .DEPTH(513),
        .ADDR_BASE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en && n_wr < 64) begin
            wa[n_wr] = wr_addr;
            wd[n_wr] = wr_data;
            wc[n_wr] = cyc;
            n_wr     = n_wr + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic idle_gap();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        tick(1);
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h,
                                input logic [15:0] ww);
        check({tag, "_done"},  {31'd0, done},     {31'd0, d});
        check({tag, "_error"}, {31'd0, error},    {31'd0, e});
        check({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, h});
        check({tag, "_words"}, {16'd0, words_written}, {16'd0, ww});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wren",  {31'd0, wr_en},    32'd0);
        check("rst_addr",  wr_addr, 32'd0);
        check("rst_data",  wr_data, 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 16'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // single word
        base = n_wr;
        pulse_start();
        check("t1_start_ready", {31'd0, in_ready}, 32'd1);
        check("t1_start_hold",  {31'd0, cpu_hold}, 32'd1);
        send(8'h01); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'hA3);
        check_status("t1", 1'b1, 1'b0, 1'b0, 16'd1);
        check("t1_nwr",  n_wr - base, 32'd1);
        check("t1_addr", wa[base], 32'h0000_0000);
        check("t1_data", wd[base], 32'h0010_0093);
        tick(2);

        // four words at full rate, checksum 0x0A
        base = n_wr;
        pulse_start();
        send(8'h04); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'h13); send(8'h01); send(8'h20); send(8'h00);
        send(8'h93); send(8'h01); send(8'h30); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        check("t2_last_wren",  {31'd0, wr_en},    32'd1);
        check("t2_last_ready", {31'd0, in_ready}, 32'd1);
        check("t2_last_done",  {31'd0, done},     32'd0);
        send(8'h0A);
        check_status("t2", 1'b1, 1'b0, 1'b0, 16'd4);
        check("t2_nwr", n_wr - base, 32'd4);
        check("t2_a0", wa[base],     32'h0000_0000);
        check("t2_a1", wa[base + 1], 32'h0000_0004);
        check("t2_a2", wa[base + 2], 32'h0000_0008);
        check("t2_a3", wa[base + 3], 32'h0000_000C);
        check("t2_d0", wd[base],     32'h0010_0093);
        check("t2_d1", wd[base + 1], 32'h0020_0113);
        check("t2_d2", wd[base + 2], 32'h0030_0193);
        check("t2_d3", wd[base + 3], 32'h0000_006F);
        check("t2_gap1", wc[base + 1] - wc[base],     32'd4);
        check("t2_gap2", wc[base + 2] - wc[base + 1], 32'd4);
        check("t2_gap3", wc[base + 3] - wc[base + 2], 32'd4);
        check("t2_hold_addr", wr_addr, 32'h0000_000C);
        check("t2_hold_data", wr_data, 32'h0000_006F);
        tick(2);

        // bad checksum
        base = n_wr;
        pulse_start();
        check("t3_start_done", {31'd0, done}, 32'd0);
        send(8'h01); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'hA4);
        check_status("t3", 1'b0, 1'b1, 1'b1, 16'd1);
        check("t3_ready", {31'd0, in_ready}, 32'd0);
        check("t3_nwr",  n_wr - base, 32'd1);
        check("t3_data", wd[base], 32'h0010_0093);
        tick(2);

        // oversize length 0x0202
        base = n_wr;
        pulse_start();
        check("t4_start_error", {31'd0, error}, 32'd0);
        send(8'h02); send(8'h02);
        check_status("t4", 1'b0, 1'b1, 1'b1, 16'd0);
        check("t4_ready", {31'd0, in_ready}, 32'd0);
        send(8'h00); send(8'h00);
        check("t4_nwr", n_wr - base, 32'd0);
        check("t4_still_error", {31'd0, error}, 32'd1);
        tick(2);

        // zero length
        base = n_wr;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        check_status("t5", 1'b1, 1'b0, 1'b0, 16'd0);
        check("t5_nwr", n_wr - base, 32'd0);
        tick(2);

        // gapped stream with an ignored start during DATA
        base = n_wr;
        pulse_start();
        send(8'h01); idle_gap(); send(8'h00);
        send(8'h13); idle_gap(); idle_gap(); send(8'h01);
        start = 1'b1; idle_gap(); start = 1'b0;
        check("t6_mid_ready", {31'd0, in_ready}, 32'd1);
        check("t6_mid_hold",  {31'd0, cpu_hold}, 32'd1);
        send(8'h20); idle_gap(); send(8'h00);
        idle_gap();
        send(8'h34);
        check_status("t6", 1'b1, 1'b0, 1'b0, 16'd1);
        check("t6_nwr",  n_wr - base, 32'd1);
        check("t6_addr", wa[base], 32'h0000_0000);
        check("t6_data", wd[base], 32'h0020_0113);
        tick(2);

        // reset after two of four data bytes
        base = n_wr;
        pulse_start();
        send(8'h01); send(8'h00); send(8'h93); send(8'h00);
        rst = 1'b1;
        #1;
        check("t7_ready", {31'd0, in_ready}, 32'd0);
        check("t7_wren",  {31'd0, wr_en},    32'd0);
        check("t7_addr",  wr_addr, 32'd0);
        check("t7_data",  wr_data, 32'd0);
        check_status("t7", 1'b0, 1'b0, 1'b0, 16'd0);
        tick(1);
        rst = 1'b0;
        send(8'h10); send(8'h00);
        tick(3);
        check("t7_nwr", n_wr - base, 32'd0);
        check("t7_idle_ready", {31'd0, in_ready}, 32'd0);

        base = n_wr;
        pulse_start();
        send(8'h01); send(8'h00);
        send(8'h93); send(8'h00); send(8'h10); send(8'h00);
        send(8'hA3);
        check_status("t8", 1'b1, 1'b0, 1'b0, 16'd1);
        check("t8_nwr",  n_wr - base, 32'd1);
        check("t8_addr", wa[base], 32'h0000_0000);
        check("t8_data", wd[base], 32'h0010_0093);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
